// File: rtl/decoder_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with 74138-style enable gating,
// extended with an auto-stepping scan mode and a one-shot timed pulse mode.
module decoder_seq #(
    parameter int SEL_W      = 3,
    parameter int PRESCALE   = 4,
    parameter int PULSE_LEN  = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    i_a,
    input  logic                i_sta,
    input  logic                i_stb,
    input  logic                i_stc,
    input  logic [1:0]          i_mode,
    input  logic                i_go,
    output logic [2**SEL_W-1:0] o_c,
    output logic [SEL_W-1:0]    o_cur_idx,
    output logic                o_wrap,
    output logic                o_busy
);
    localparam int N    = 2**SEL_W;
    localparam int PS_W = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
    localparam int PL_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PL_W-1:0]  PL_MAX  = PL_W'(PULSE_LEN - 1);
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);
    localparam logic [N-1:0]     INACT   = {N{ACTIVE_LOW}};

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;

    typedef enum logic {S_IDLE, S_PULSE} state_t;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic [N-1:0]     r_c;
    logic [SEL_W-1:0] r_cur_idx;
    logic             r_wrap;
    logic             r_busy;
    state_t           r_state;
    logic [PS_W-1:0]  r_pre_cnt;
    logic [PL_W-1:0]  r_pulse_cnt;
    logic [SEL_W-1:0] r_scan_idx;
    logic             r_scan_act;
    logic [SEL_W-1:0] r_pulse_sel;

    logic             w_p;
    logic [SEL_W-1:0] w_step_idx;
    logic [N-1:0]     w_dec_nxt;
    logic [SEL_W-1:0] w_cur_idx_nxt;
    logic             w_wrap_nxt;
    logic             w_busy_nxt;
    state_t           w_state_nxt;
    logic [PS_W-1:0]  w_pre_nxt;
    logic [PL_W-1:0]  w_pulse_cnt_nxt;
    logic [SEL_W-1:0] w_scan_idx_nxt;
    logic             w_scan_act_nxt;
    logic [SEL_W-1:0] w_pulse_sel_nxt;

    assign w_p        = i_sta & ~i_stb & ~i_stc;
    assign w_step_idx = r_scan_idx + 1'b1;

    always_comb begin
        w_dec_nxt       = '0;
        w_cur_idx_nxt   = '0;
        w_wrap_nxt      = 1'b0;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = S_IDLE;
        w_pre_nxt       = r_pre_cnt;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_scan_idx_nxt  = r_scan_idx;
        w_scan_act_nxt  = 1'b0;
        w_pulse_sel_nxt = r_pulse_sel;

        case (i_mode)
            MODE_DIRECT: begin
                if (w_p) begin
                    w_dec_nxt     = onehot(i_a);
                    w_cur_idx_nxt = i_a;
                end
            end
            MODE_SCAN: begin
                // Entry completes only once enabled, so ch0 always gets a full slot
                w_scan_act_nxt = r_scan_act | w_p;
                if (!r_scan_act) begin
                    w_scan_idx_nxt = '0;
                    w_pre_nxt      = '0;
                    if (w_p) begin
                        w_dec_nxt = onehot('0);
                    end
                end else if (w_p) begin
                    if (r_pre_cnt == PS_MAX) begin
                        w_pre_nxt      = '0;
                        w_scan_idx_nxt = w_step_idx;
                        w_wrap_nxt     = (r_scan_idx == IDX_MAX);
                        w_dec_nxt      = onehot(w_step_idx);
                        w_cur_idx_nxt  = w_step_idx;
                    end else begin
                        w_pre_nxt     = r_pre_cnt + 1'b1;
                        w_dec_nxt     = onehot(r_scan_idx);
                        w_cur_idx_nxt = r_scan_idx;
                    end
                end
            end
            MODE_PULSE: begin
                if (r_state == S_IDLE) begin
                    if (w_p && i_go) begin
                        w_state_nxt     = S_PULSE;
                        w_pulse_sel_nxt = i_a;
                        w_pulse_cnt_nxt = PL_MAX;
                        w_dec_nxt       = onehot(i_a);
                        w_cur_idx_nxt   = i_a;
                        w_busy_nxt      = 1'b1;
                    end
                end else if (w_p && (r_pulse_cnt != '0)) begin
                    w_state_nxt     = S_PULSE;
                    w_pulse_cnt_nxt = r_pulse_cnt - 1'b1;
                    w_dec_nxt       = onehot(r_pulse_sel);
                    w_cur_idx_nxt   = r_pulse_sel;
                    w_busy_nxt      = 1'b1;
                end
            end
            default: begin
                w_pre_nxt       = '0;
                w_pulse_cnt_nxt = '0;
                w_scan_idx_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c         <= INACT;
            r_cur_idx   <= '0;
            r_wrap      <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
            r_pre_cnt   <= '0;
            r_pulse_cnt <= '0;
            r_scan_idx  <= '0;
            r_scan_act  <= 1'b0;
            r_pulse_sel <= '0;
        end else begin
            r_c         <= w_dec_nxt ^ INACT;
            r_cur_idx   <= w_cur_idx_nxt;
            r_wrap      <= w_wrap_nxt;
            r_busy      <= w_busy_nxt;
            r_state     <= w_state_nxt;
            r_pre_cnt   <= w_pre_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
            r_scan_idx  <= w_scan_idx_nxt;
            r_scan_act  <= w_scan_act_nxt;
            r_pulse_sel <= w_pulse_sel_nxt;
        end
    end

    assign o_c       = r_c;
    assign o_cur_idx = r_cur_idx;
    assign o_wrap    = r_wrap;
    assign o_busy    = r_busy;

endmodule
